// File: rtl/banco_registradores_ula_pkg.sv
// banco_registradores_ula_pkg: shared datapath constants and types for the register file, ALU and control
package banco_registradores_ula_pkg;
    localparam int WIDTH = 32;
    localparam int NREG = 32;
    localparam int AW = $clog2(NREG);
    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [WIDTH-1:0] word_t;
    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/banco_registradores_ula.sv
// banco_registradores_ula: register file with zero register and DIV remainder register
// define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports
module banco_registradores_ula
    import banco_registradores_ula_pkg::*;
(
    input  logic      CLK,
    input  logic      RST_N,
    input  reg_addr_t RA1,
    input  reg_addr_t RA2,
    output word_t     D1,
    output word_t     D2,
    input  logic      WE,
    input  reg_addr_t WA,
    input  word_t     WD,
    input  logic      RESTO_WE,
    input  word_t     RESTO_IN,
    output word_t     RESTO_OUT
);
    word_t regs [NREG];
    word_t resto;
    word_t rd1, rd2;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            resto <= '0;
        end else begin
            if (WE && WA != REG_ZERO) regs[WA] <= WD;
            if (RESTO_WE) resto <= RESTO_IN;
        end
    end
    always_comb begin
        rd1 = (RA1 == REG_ZERO) ? '0 : regs[RA1];
        rd2 = (RA2 == REG_ZERO) ? '0 : regs[RA2];
    end
`ifdef REGFILE_BYPASS_EN
    always_comb begin
        D1 = (WE && WA != REG_ZERO && RA1 == WA) ? WD : rd1;
        D2 = (WE && WA != REG_ZERO && RA2 == WA) ? WD : rd2;
        RESTO_OUT = RESTO_WE ? RESTO_IN : resto;
    end
`else
    always_comb begin
        D1 = rd1;
        D2 = rd2;
        RESTO_OUT = resto;
    end
`endif
endmodule

// File: tb/tb_banco_registradores_ula.sv
// tb_banco_registradores_ula: directed self-checking bench for the register file
module tb_banco_registradores_ula;
    logic        CLK = 0;
    logic        RST_N;
    logic [4:0]  RA1, RA2, WA;
    logic [31:0] D1, D2, WD, RESTO_IN, RESTO_OUT;
    logic        WE, RESTO_WE;
    int total = 0;
    int bad = 0;

    banco_registradores_ula dut (
        .CLK(CLK), .RST_N(RST_N), .RA1(RA1), .RA2(RA2), .D1(D1), .D2(D2),
        .WE(WE), .WA(WA), .WD(WD), .RESTO_WE(RESTO_WE), .RESTO_IN(RESTO_IN),
        .RESTO_OUT(RESTO_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 0; RA1 = 0; RA2 = 0; WE = 1; WA = 3; WD = 55;
        RESTO_WE = 1; RESTO_IN = 77;
        tick; tick;
        chk("rst_d1", D1, 0);
        chk("rst_d2", D2, 0);
        chk("rst_resto", RESTO_OUT, 0);
        WE = 0; RESTO_WE = 0; RST_N = 1;
        RA1 = 3; RA2 = 3;
        tick;
        chk("wr_in_rst_reg3", D1, 0);
        chk("wr_in_rst_resto", RESTO_OUT, 0);
        // fill reg5 and the remainder, then clear them with a mid-cycle reset pulse
        WE = 1; WA = 5; WD = 32'hDEAD_BEEF; RESTO_WE = 1; RESTO_IN = 7;
        tick;
        WE = 0; RESTO_WE = 0; RA1 = 5; RA2 = 0;
        #1;
        chk("reg5_written", D1, 32'hDEAD_BEEF);
        chk("resto_written", RESTO_OUT, 7);
        RST_N = 0;
        #1;
        chk("async_clr_d1", D1, 0);
        chk("async_clr_resto", RESTO_OUT, 0);
        RST_N = 1;
        tick;
        chk("post_clr_reg5", D1, 0);
        WE = 1; WA = 7; WD = 123;
        tick;
        WE = 0; RA1 = 7; RA2 = 7;
        #1;
        chk("wr7_d1", D1, 123);
        chk("wr7_d2", D2, 123);
        WE = 1; WA = 0; WD = 32'hFFFF_FFFF;
        tick;
        WE = 0; RA1 = 0;
        #1;
        chk("reg0_d1", D1, 0);
        chk("reg0_other_d2", D2, 123);
        WE = 1; WA = 2; WD = 2; RESTO_WE = 1; RESTO_IN = 3;
        tick;
        WE = 0; RESTO_WE = 0; RA1 = 2; RA2 = 7;
        #1;
        chk("div_reg2", D1, 2);
        chk("div_d2_reg7", D2, 123);
        chk("div_resto", RESTO_OUT, 3);
        WE = 1; WA = 4; WD = 10;
        tick;
        WD = 99; RA1 = 4; RA2 = 2; RESTO_WE = 1; RESTO_IN = 9;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("hazard_pre_d1", D1, 99);
        chk("hazard_pre_resto", RESTO_OUT, 9);
`else
        chk("hazard_pre_d1", D1, 10);
        chk("hazard_pre_resto", RESTO_OUT, 3);
`endif
        chk("hazard_pre_d2", D2, 2);
        tick;
        WE = 0; RESTO_WE = 0;
        #1;
        chk("hazard_post_d1", D1, 99);
        chk("hazard_post_resto", RESTO_OUT, 9);
        RA1 = 7; RA2 = 4;
        #1;
        chk("final_d1_reg7", D1, 123);
        chk("final_d2_reg4", D2, 99);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
